// File: rtl/eq_match_if.sv
// Bundle of the comparator-side input and the debounced status outputs of eq_match_monitor.
// The master drives the raw equality bit and the count clear; the slave is the monitor.
interface eq_match_if #(
    parameter int CNT_W = 8
) ();
    logic             aeqb;
    logic             clr_count;
    logic             eq_stable;
    logic             match_pulse;
    logic             mismatch_pulse;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;

    modport master (
        output aeqb,
        output clr_count,
        input  eq_stable,
        input  match_pulse,
        input  mismatch_pulse,
        input  match_count,
        input  count_sat
    );

    modport slave (
        input  aeqb,
        input  clr_count,
        output eq_stable,
        output match_pulse,
        output mismatch_pulse,
        output match_count,
        output count_sat
    );
endinterface

// File: rtl/eq_match_monitor.sv
// Synchronises and debounces the comparator's aeqb bit, emits match/mismatch pulses
// and keeps a saturating count of match events.
module eq_match_monitor #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    eq_match_if.slave  bus
);
    localparam int                DB_W    = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_ZERO = {DB_W{1'b0}};
    localparam logic [DB_W-1:0]   DB_ONE  = DB_W'(1'b1);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_NE      = 2'd0,
        ST_NE_PEND = 2'd1,
        ST_EQ      = 2'd2,
        ST_EQ_PEND = 2'd3
    } state_t;

    logic             s1_q, s1_d, s2_q, s2_d;
    state_t           state_q, state_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             eq_stable_q, eq_stable_d;
    logic             match_pulse_q, match_pulse_d;
    logic             mismatch_pulse_q, mismatch_pulse_d;
    logic [CNT_W-1:0] match_count_q, match_count_d;
    logic             rise_s, fall_s;

    // Debounce FSM next state; a run that breaks before DB_CYCLES samples drops back to the stable state
    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        case (state_q)
            ST_NE: begin
                if (!s2_q) begin
                    state_d  = ST_NE;
                    db_cnt_d = DB_ZERO;
                end else if (DB_CYCLES == 32'sd1) begin
                    state_d  = ST_EQ;
                    db_cnt_d = DB_ZERO;
                end else begin
                    state_d  = ST_NE_PEND;
                    db_cnt_d = DB_ONE;
                end
            end
            ST_NE_PEND: begin
                if (!s2_q) begin
                    state_d  = ST_NE;
                    db_cnt_d = DB_ZERO;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = ST_EQ;
                    db_cnt_d = DB_ZERO;
                end else begin
                    state_d  = ST_NE_PEND;
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            ST_EQ: begin
                if (s2_q) begin
                    state_d  = ST_EQ;
                    db_cnt_d = DB_ZERO;
                end else if (DB_CYCLES == 32'sd1) begin
                    state_d  = ST_NE;
                    db_cnt_d = DB_ZERO;
                end else begin
                    state_d  = ST_EQ_PEND;
                    db_cnt_d = DB_ONE;
                end
            end
            ST_EQ_PEND: begin
                if (s2_q) begin
                    state_d  = ST_EQ;
                    db_cnt_d = DB_ZERO;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = ST_NE;
                    db_cnt_d = DB_ZERO;
                end else begin
                    state_d  = ST_EQ_PEND;
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            default: begin
                state_d  = ST_NE;
                db_cnt_d = DB_ZERO;
            end
        endcase
    end

    // Flag, edge pulses and the saturating counter; clear wins over a coincident match
    always_comb begin
        s1_d             = bus.aeqb;
        s2_d             = s1_q;
        rise_s           = (state_d == ST_EQ) && ((state_q == ST_NE) || (state_q == ST_NE_PEND));
        fall_s           = (state_d == ST_NE) && ((state_q == ST_EQ) || (state_q == ST_EQ_PEND));
        eq_stable_d      = (state_d == ST_EQ) || (state_d == ST_EQ_PEND);
        match_pulse_d    = rise_s;
        mismatch_pulse_d = fall_s;
        if (bus.clr_count) begin
            match_count_d = {CNT_W{1'b0}};
        end else if (rise_s && (match_count_q != CNT_MAX)) begin
            match_count_d = match_count_q + CNT_ONE;
        end else begin
            match_count_d = match_count_q;
        end
    end

    // All state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q             <= 1'b0;
            s2_q             <= 1'b0;
            state_q          <= ST_NE;
            db_cnt_q         <= {DB_W{1'b0}};
            eq_stable_q      <= 1'b0;
            match_pulse_q    <= 1'b0;
            mismatch_pulse_q <= 1'b0;
            match_count_q    <= {CNT_W{1'b0}};
        end else begin
            s1_q             <= s1_d;
            s2_q             <= s2_d;
            state_q          <= state_d;
            db_cnt_q         <= db_cnt_d;
            eq_stable_q      <= eq_stable_d;
            match_pulse_q    <= match_pulse_d;
            mismatch_pulse_q <= mismatch_pulse_d;
            match_count_q    <= match_count_d;
        end
    end

    assign bus.eq_stable      = eq_stable_q;
    assign bus.match_pulse    = match_pulse_q;
    assign bus.mismatch_pulse = mismatch_pulse_q;
    assign bus.match_count    = match_count_q;
    assign bus.count_sat      = (match_count_q == CNT_MAX);
endmodule

// File: tb/tb_eq_match_monitor.sv
// Directed bench for eq_match_monitor: two instances (8-bit and 2-bit counters) share one
// stimulus stream; expectations are queued per step and checked after each clock edge.
module tb_eq_match_monitor;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    eq_match_if #(.CNT_W(8)) bus_a ();
    eq_match_if #(.CNT_W(2)) bus_b ();

    eq_match_monitor #(.DB_CYCLES(4), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    eq_match_monitor #(.DB_CYCLES(4), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    typedef struct {
        string      tag;
        logic       eq;
        logic       mp;
        logic       mmp;
        logic [7:0] cnt_a;
        logic [1:0] cnt_b;
        logic       sat_b;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_a = 8'd0;
    logic [1:0] exp_b = 2'd0;

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic a, input logic c);
        bus_a.aeqb = a; bus_b.aeqb = a;
        bus_a.clr_count = c; bus_b.clr_count = c;
    endtask

    task automatic push(input string tag, input logic eq, input logic mp, input logic mmp);
        exp_t e;
        e.tag = tag; e.eq = eq; e.mp = mp; e.mmp = mmp;
        e.cnt_a = exp_a; e.cnt_b = exp_b; e.sat_b = (exp_b == 2'b11);
        sb_q.push_back(e);
    endtask

    task automatic check_head();
        exp_t e;
        if (sb_q.size() == 0) begin
            cmp("scoreboard_empty", 8'd0, 8'd1);
        end else begin
            e = sb_q.pop_front();
            cmp({e.tag, "_eq_a"},  {7'd0, bus_a.eq_stable},      {7'd0, e.eq});
            cmp({e.tag, "_eq_b"},  {7'd0, bus_b.eq_stable},      {7'd0, e.eq});
            cmp({e.tag, "_mp_a"},  {7'd0, bus_a.match_pulse},    {7'd0, e.mp});
            cmp({e.tag, "_mp_b"},  {7'd0, bus_b.match_pulse},    {7'd0, e.mp});
            cmp({e.tag, "_mmp_a"}, {7'd0, bus_a.mismatch_pulse}, {7'd0, e.mmp});
            cmp({e.tag, "_mmp_b"}, {7'd0, bus_b.mismatch_pulse}, {7'd0, e.mmp});
            cmp({e.tag, "_cnt_a"}, bus_a.match_count,            e.cnt_a);
            cmp({e.tag, "_cnt_b"}, {6'd0, bus_b.match_count},    {6'd0, e.cnt_b});
            cmp({e.tag, "_sat_a"}, {7'd0, bus_a.count_sat},      8'd0);
            cmp({e.tag, "_sat_b"}, {7'd0, bus_b.count_sat},      {7'd0, e.sat_b});
        end
    endtask

    task automatic expect_now(input string tag, input logic eq, input logic mp, input logic mmp);
        push(tag, eq, mp, mmp);
        check_head();
    endtask

    task automatic step(input string tag, input logic eq, input logic mp, input logic mmp);
        push(tag, eq, mp, mmp);
        @(posedge clk); #1;
        check_head();
    endtask

    task automatic rise(input string tag, input logic clr);
        set_in(1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) step({tag, "_pend"}, 1'b0, 1'b0, 1'b0);
        set_in(1'b1, clr);
        if (clr) begin
            exp_a = 8'd0; exp_b = 2'd0;
        end else begin
            if (exp_a != 8'hFF) exp_a = exp_a + 8'd1;
            if (exp_b != 2'b11) exp_b = exp_b + 2'd1;
        end
        step({tag, "_edge6"}, 1'b1, 1'b1, 1'b0);
        set_in(1'b1, 1'b0);
        step({tag, "_edge7"}, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic fall(input string tag);
        set_in(1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) step({tag, "_pend"}, 1'b1, 1'b0, 1'b0);
        step({tag, "_edge6"}, 1'b0, 1'b0, 1'b1);
        step({tag, "_edge7"}, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 1'b0);
        #2;
        expect_now("reset_init", 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 1'b0);

        rise("E1", 1'b0);

        // three low samples from EQ must not disturb the flag
        set_in(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("glitch_lo", 1'b1, 1'b0, 1'b0);
        set_in(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("glitch_lo_ret", 1'b1, 1'b0, 1'b0);
        fall("F1");

        // three high samples from NE, then a full-latency rise proves db_cnt restarted
        set_in(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("glitch_hi", 1'b0, 1'b0, 1'b0);
        set_in(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("glitch_hi_ret", 1'b0, 1'b0, 1'b0);
        rise("E2", 1'b0);
        fall("F2");

        rise("E3_clr", 1'b1);
        fall("F3");

        for (int k = 4; k <= 7; k++) begin
            rise($sformatf("E%0d", k), 1'b0);
            fall($sformatf("F%0d", k));
        end
        rise("E8", 1'b0);

        // reset while pending towards NE, with match_count at 5
        set_in(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_a = 8'd0; exp_b = 2'd0;
        expect_now("reset_async", 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step("post_rst", 1'b0, 1'b0, 1'b0);

        if (sb_q.size() != 0) cmp("scoreboard_leftover", 8'(sb_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
